// File: rtl/if_id_queue_pkg.sv
// Shared pipeline defines and types for the IF/ID instruction queue.
package if_id_queue_pkg;

  localparam logic        Stop       = 1'b1;
  localparam logic        NoStop     = 1'b0;
  localparam logic [31:0] ZeroWord   = 32'h0000_0000;
  localparam logic        RstEnable  = 1'b0;
  localparam int unsigned StallIdBit = 2;

  typedef enum logic [2:0] {
    OUT_HOLD,
    OUT_FLUSH,
    OUT_HEAD,
    OUT_BYPASS,
    OUT_BUBBLE
  } out_sel_e;

  function automatic logic addr_misaligned(input logic [1:0] pc_lo);
    return pc_lo != 2'b00;
  endfunction

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-side and decode-side signal bundle of the IF/ID queue.
// The id_excp_adel wire exists only when IF_ID_EXCP_EN is defined.
interface if_id_queue_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] if_pc;
  logic [INST_W-1:0] if_inst;
  logic              if_valid;
  logic              if_ready;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;
  logic              id_valid;
  logic [CNT_W-1:0]  count;
`ifdef IF_ID_EXCP_EN
  logic              id_excp_adel;

  modport master (
    output if_pc, if_inst, if_valid,
    input  if_ready, id_pc, id_inst, id_valid, count, id_excp_adel
  );

  modport slave (
    input  if_pc, if_inst, if_valid,
    output if_ready, id_pc, id_inst, id_valid, count, id_excp_adel
  );
`else
  modport master (
    output if_pc, if_inst, if_valid,
    input  if_ready, id_pc, id_inst, id_valid, count
  );

  modport slave (
    input  if_pc, if_inst, if_valid,
    output if_ready, id_pc, id_inst, id_valid, count
  );
`endif

endinterface

// File: rtl/if_id_queue_fifo_sync.sv
// Plain synchronous FIFO with separate occupancy counter; no bypass path.
module fifo_sync
  import if_id_queue_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         data,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full & ~clear;
  assign do_pop  = pop & ~empty & ~clear;
  assign head    = mem[rd_ptr];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (clear) begin
      // Emptying only needs the read side to catch up with the write side.
      rd_ptr  <= wr_ptr;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data;
  end

endmodule

// File: rtl/if_id_queue.sv
// Fetch-decode buffer: DEPTH-entry instruction queue plus registered ID stage.
// Define IF_ID_EXCP_EN to carry an address-misalignment flag with each entry.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  if_id_queue_if.slave bus
);
`ifdef IF_ID_EXCP_EN
  localparam int unsigned ENT_W = ADDR_W + INST_W + 1;
`else
  localparam int unsigned ENT_W = ADDR_W + INST_W;
`endif

  logic [ENT_W-1:0]         in_entry;
  logic [ENT_W-1:0]         head;
  logic [ENT_W-1:0]         out_q;
  logic                     valid_q;
  logic                     full;
  logic                     empty;
  logic                     ready;
  logic                     enq;
  logic                     adv;
  logic                     push;
  logic                     pop;
  logic [$clog2(DEPTH):0]   count;
  logic                     unused_stall;
  out_sel_e                 sel;

`ifdef IF_ID_EXCP_EN
  assign in_entry = {addr_misaligned(bus.if_pc[1:0]), bus.if_pc, bus.if_inst};
`else
  assign in_entry = {bus.if_pc, bus.if_inst};
`endif

  assign unused_stall = ^{stall[5:3], stall[1:0]};

  assign ready = ~full;
  assign enq   = bus.if_valid & ready & ~flush;
  assign adv   = (stall[StallIdBit] == NoStop);

  // An entry bypasses the queue only when ID advances into an empty queue,
  // so nothing already buffered can be overtaken.
  assign push = enq & ~(adv & empty);
  assign pop  = adv & ~empty & ~flush;

  fifo_sync #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (flush),
    .data  (in_entry),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    sel = OUT_HOLD;
    if (flush)             sel = OUT_FLUSH;
    else if (adv && !empty) sel = OUT_HEAD;
    else if (adv && enq)   sel = OUT_BYPASS;
    else if (adv)          sel = OUT_BUBBLE;
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (sel)
        OUT_FLUSH, OUT_BUBBLE: begin
          out_q   <= '0;
          valid_q <= 1'b0;
        end
        OUT_HEAD: begin
          out_q   <= head;
          valid_q <= 1'b1;
        end
        OUT_BYPASS: begin
          out_q   <= in_entry;
          valid_q <= 1'b1;
        end
        default: begin
          out_q   <= out_q;
          valid_q <= valid_q;
        end
      endcase
    end
  end

  assign bus.if_ready = ready;
  assign bus.id_inst  = out_q[INST_W-1:0];
  assign bus.id_pc    = out_q[INST_W +: ADDR_W];
  assign bus.id_valid = valid_q;
  assign bus.count    = count;
`ifdef IF_ID_EXCP_EN
  assign bus.id_excp_adel = out_q[ENT_W-1];
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: accepted fetches are queued as expected
// ID outputs and a negedge monitor checks every presented output stage.
module tb_if_id_queue;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;
  localparam int unsigned DEPTH  = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        excp;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] stall = 6'b0;
  logic       flush = 1'b0;
  logic       exp_acc = 1'b0;

  ent_t sb[$];
  ent_t e = '0;
  logic e_v = 1'b0;
  logic started = 1'b0;
  logic rst_p = 1'b0;
  logic flush_p = 1'b0;
  logic adv_p = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  if_id_queue_if #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH)) bus ();

  if_id_queue #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected entries are recorded at the accepting edge.
  always @(posedge clk) begin
    started <= 1'b1;
    rst_p   <= rst;
    flush_p <= flush;
    adv_p   <= !stall[2];
    if (!rst || flush)
      sb.delete();
    else if (bus.if_valid && exp_acc)
      sb.push_back('{pc: bus.if_pc, inst: bus.if_inst, excp: (bus.if_pc[1:0] != 2'b00)});
  end

  always @(negedge clk) begin
    if (started) begin
      if (!rst_p || flush_p) begin
        e = '0; e_v = 1'b0;
      end else if (adv_p) begin
        if (sb.size() > 0) begin
          e = sb.pop_front(); e_v = 1'b1;
        end else begin
          e = '0; e_v = 1'b0;
        end
      end
      chk("mon_id_valid", 64'(bus.id_valid), 64'(e_v));
      chk("mon_id_pc",    64'(bus.id_pc),    64'(e.pc));
      chk("mon_id_inst",  64'(bus.id_inst),  64'(e.inst));
`ifdef IF_ID_EXCP_EN
      chk("mon_id_excp_adel", 64'(bus.id_excp_adel), 64'(e.excp));
`endif
    end
  end

  task automatic drive(input logic v, input logic [31:0] pc, input logic s2,
                       input logic fl, input logic acc);
    bus.if_valid = v;
    bus.if_pc    = pc;
    bus.if_inst  = {16'hC0DE, pc[15:0]};
    stall        = s2 ? 6'b000100 : 6'b101011;
    flush        = fl;
    exp_acc      = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic ck_q(input string tag, input int cnt, input logic rdy);
    chk({tag, "_count"},    64'(bus.count),    64'(cnt));
    chk({tag, "_if_ready"}, 64'(bus.if_ready), 64'(rdy));
  endtask

  initial begin
    bus.if_valid = 1'b0;
    bus.if_pc    = '0;
    bus.if_inst  = '0;

    // Reset held with IF offering an entry.
    rst = 1'b0;
    drive(1, 32'h050, 0, 0, 0);
    drive(1, 32'h054, 0, 0, 0);
    chk("rst_id_valid", 64'(bus.id_valid), 64'd0);
    chk("rst_id_pc",    64'(bus.id_pc),    64'd0);
    chk("rst_id_inst",  64'(bus.id_inst),  64'd0);
    ck_q("rst", 0, 1);
    rst = 1'b1;

    // Passthrough: one-cycle latency, queue untouched.
    drive(1, 32'h100, 0, 0, 1); chk("pass0_pc", 64'(bus.id_pc), 64'h100); ck_q("pass0", 0, 1);
    drive(1, 32'h104, 0, 0, 1); chk("pass1_pc", 64'(bus.id_pc), 64'h104); ck_q("pass1", 0, 1);
    drive(1, 32'h108, 0, 0, 1); chk("pass2_pc", 64'(bus.id_pc), 64'h108); ck_q("pass2", 0, 1);
    drive(0, 32'h0, 0, 0, 0);   chk("pass_bubble", 64'(bus.id_valid), 64'd0);

    // Fill under stall, fifth entry refused, then drain in order.
    drive(1, 32'h200, 1, 0, 1); ck_q("fill1", 1, 1);
    drive(1, 32'h204, 1, 0, 1); ck_q("fill2", 2, 1);
    drive(1, 32'h208, 1, 0, 1); ck_q("fill3", 3, 1);
    drive(1, 32'h20C, 1, 0, 1); ck_q("fill4", 4, 0);
    drive(1, 32'h210, 1, 0, 0); ck_q("fill5", 4, 0);
    chk("fill_out_bubble", 64'(bus.id_valid), 64'd0);
    drive(1, 32'h210, 0, 0, 0); ck_q("drain0", 3, 1); chk("drain0_pc", 64'(bus.id_pc), 64'h200);
    drive(1, 32'h210, 0, 0, 1); ck_q("drain1", 3, 1); chk("drain1_pc", 64'(bus.id_pc), 64'h204);
    drive(0, 32'h0, 0, 0, 0);   ck_q("drain2", 2, 1);
    drive(0, 32'h0, 0, 0, 0);   ck_q("drain3", 1, 1);
    drive(0, 32'h0, 0, 0, 0);   ck_q("drain4", 0, 1); chk("drain4_pc", 64'(bus.id_pc), 64'h210);
    drive(0, 32'h0, 0, 0, 0);   chk("drain_bubble", 64'(bus.id_valid), 64'd0);

    // Flush with three queued, a valid output and a stalled ID.
    drive(1, 32'h300, 0, 0, 1); ck_q("fl0", 0, 1);
    drive(1, 32'h304, 1, 0, 1); ck_q("fl1", 1, 1);
    drive(1, 32'h308, 1, 0, 1); ck_q("fl2", 2, 1);
    drive(1, 32'h30C, 1, 0, 1); ck_q("fl3", 3, 1);
    chk("fl_pre_valid", 64'(bus.id_valid), 64'd1);
    drive(1, 32'h310, 1, 1, 0); ck_q("flush", 0, 1);
    chk("flush_id_valid", 64'(bus.id_valid), 64'd0);
    drive(0, 32'h0, 0, 0, 0);   ck_q("post_flush", 0, 1);
    chk("post_flush_valid", 64'(bus.id_valid), 64'd0);

    // Steady push+pop at count 2 across several pointer wraps.
    drive(1, 32'h400, 0, 0, 1); ck_q("pp0", 0, 1);
    drive(1, 32'h404, 1, 0, 1); ck_q("pp1", 1, 1);
    drive(1, 32'h408, 1, 0, 1); ck_q("pp2", 2, 1);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      drive(1, 32'h40C + 32'(4 * i), 0, 0, 1);
      ck_q("pp_steady", 2, 1);
    end
    drive(0, 32'h0, 0, 0, 0); ck_q("pp_d1", 1, 1);
    drive(0, 32'h0, 0, 0, 0); ck_q("pp_d2", 0, 1);
    drive(0, 32'h0, 0, 0, 0); ck_q("pp_d3", 0, 1);
    chk("pp_bubble", 64'(bus.id_valid), 64'd0);

`ifdef IF_ID_EXCP_EN
    drive(1, 32'h102, 0, 0, 1);
    chk("adel_pc",  64'(bus.id_pc), 64'h102);
    chk("adel_set", 64'(bus.id_excp_adel), 64'd1);
    drive(1, 32'h104, 0, 0, 1);
    chk("adel_clr", 64'(bus.id_excp_adel), 64'd0);
    drive(0, 32'h0, 0, 0, 0);
    chk("adel_bubble", 64'(bus.id_excp_adel), 64'd0);
`endif

    @(negedge clk);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

- Parametrised fetch-decode buffer that replaces the single IF/ID pipeline register with a DEPTH-entry instruction queue and a registered ID-side output stage.
- IF keeps fetching while ID is stalled, up to the queue capacity.
- A branch or exception flush empties the queue and the output stage in one cycle.
- Sits between the PC/ROM fetch path and the ID stage, driven by the global stall vector from the pipeline controller.

## Interface

Parameters:
- ADDR_W, 32, PC width
- INST_W, 32, instruction width
- DEPTH, 4, number of queue entries; power of two, at least 2

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-low
- if_pc  in  ADDR_W  PC of the fetched instruction
- if_inst  in  INST_W  fetched instruction
- if_valid  in  1  IF offers an entry this cycle
- if_ready  out  1  queue can accept an entry; equals ~full; registered
- stall  in  6  controller stall vector; stall[2] = ID stalled (`Stop`)
- flush  in  1  discard all buffered and output instructions
- id_pc  out  ADDR_W  PC presented to ID
- id_inst  out  INST_W  instruction presented to ID
- id_valid  out  1  id_pc and id_inst hold a real instruction, not a bubble
- count  out  $clog2(DEPTH)+1  number of entries in the queue, excluding the output stage

## Operation

- Enqueue (enq) = if_valid & if_ready & ~flush.
- ID advance (adv) = (stall[2] == `NoStop`).
- Output stage priority, highest first:
  1. Reset: all outputs zero; if_ready = 1.
  2. flush: output stage becomes zero (bubble); queue emptied; enq suppressed.
  3. adv with queue non-empty: load head entry into the output stage, pop it; enq in the same cycle writes the tail.
  4. adv with queue empty and enq: bypass; the incoming entry goes straight into the output stage and the queue stays empty.
  5. adv with queue empty and no enq: output a bubble (id_pc, id_inst = `ZeroWord`, id_valid = 0).
  6. not adv: output stage holds its value; enq writes the tail.
- Order is preserved across bypass and queue paths; an entry never overtakes an older one.
- Full:
  - if_ready = 0 when count == DEPTH, evaluated after the edge.
  - No same-cycle pop-then-push credit.
- Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
- count is held in a separate counter: +1 on a push, −1 on a pop, unchanged on a simultaneous push and pop.

## Timing

- Bypass latency: an entry offered at edge N with an empty queue and adv appears on the id_* outputs after edge N.
  - This is the same single-cycle latency as a plain pipeline register.
- Queued latency: at least 2 cycles.
- flush at edge N: after N, id_valid = 0, count = 0, if_ready = 1; the entry offered at N is dropped.
- Reset mid-operation: same result as flush, plus all pointers are zeroed.
- stall[2] together with flush: flush wins.

## Configuration

- Macro: IF_ID_EXCP_EN.
- When defined:
  - Each entry carries an extra bit, excp_adel = (if_pc[1:0] != 2'b00).
  - It is presented on an added output id_excp_adel (1 bit; zero on reset, bubble and flush).
  - It follows exactly the same path and timing as id_pc.
- When undefined: the port and the storage bit are absent; behaviour is otherwise identical.

## Structure

- Shared defines package holds `Stop`, `NoStop`, `ZeroWord` and `RstEnable` (1'b0 for this block).
- One sub-module: fifo_sync.
  - Parameters: WIDTH and DEPTH.
  - Ports: push, pop, clear, full, empty, count, and head data.
  - It has no bypass logic.
- if_id_queue owns the bypass and bubble decision and the output stage.

## Test plan

- Reset: rst = 0 for 2 cycles with if_valid = 1 → all id_* = 0, count = 0, if_ready = 1.
- Passthrough: stall = 0, push pc 0x100, 0x104, 0x108 on consecutive cycles → id_pc = 0x100, 0x104, 0x108 one cycle later each, count stays 0.
- Fill and drain:
  - Hold stall[2] = 1 and push 5 entries with DEPTH = 4.
  - Expect 4 accepted; if_ready = 0 from the 4th acceptance; the 5th is held by IF.
  - Release the stall → entries exit in order, one per cycle, then id_valid = 0.
- Flush: with count = 3 and a valid output stage, assert flush together with if_valid → next cycle id_valid = 0, count = 0; the flush-cycle entry never appears.
- Simultaneous push and pop with count = 2 → count stays 2; pointer wrap is exercised over 3×DEPTH cycles and order is preserved.
- IF_ID_EXCP_EN: push pc 0x102 → id_excp_adel = 1 alongside id_pc = 0x102; it is 0 for 0x104.
